// File: rtl/fb_scan_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_scan_arbiter_if                                                       |
// | Paint-engine side of the framebuffer arbiter: write handshake and clear  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fb_scan_arbiter_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [8:0]  wr_data;
  logic        clr_req;
  logic [8:0]  clr_color;
  logic        clr_busy;
  logic        clr_done;

  modport master (
    output wr_valid, wr_addr, wr_data, clr_req, clr_color,
    input  wr_ready, clr_busy, clr_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, clr_req, clr_color,
    output wr_ready, clr_busy, clr_done
  );
endinterface
`default_nettype wire

// File: rtl/fb_scan_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_scan_arbiter                                                          |
// | Single-port framebuffer sharing: VGA scan fetch, paint writes, clear     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fb_scan_arbiter #(
  parameter int HBP  = 144,
  parameter int HFP  = 784,
  parameter int VBP  = 31,
  parameter int VFP  = 511,
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input  logic              dclk,
  input  logic              clr_n,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output logic [8:0]        color,
  fb_scan_arbiter_if.slave  paint,
  output logic              ram_en,
  output logic              ram_we,
  output logic [14:0]       ram_addr,
  output logic [8:0]        ram_wdata,
  input  logic [8:0]        ram_rdata
);

  localparam logic [9:0]  c_HBP        = 10'(HBP);
  localparam logic [9:0]  c_HFP        = 10'(HFP);
  localparam logic [9:0]  c_VBP        = 10'(VBP);
  localparam logic [9:0]  c_VFP        = 10'(VFP);
  localparam logic [9:0]  c_SLOT_FIRST = 10'(HBP - 2);
  localparam logic [9:0]  c_SLOT_LAST  = 10'(HFP - 6);
  localparam logic [14:0] c_FB_W       = 15'(FB_W);
  localparam logic [14:0] c_CELLS      = 15'(FB_W * FB_H);
  localparam logic [14:0] c_CELL_LAST  = 15'(FB_W * FB_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic        w_vact;
  logic        w_hact;
  logic        w_active;
  logic [1:0]  w_hphase;
  logic        w_slot;
  logic [14:0] w_scan_addr;

  logic [7:0]  r_col;
  logic [1:0]  r_vsub;
  logic [14:0] r_row_base;
  logic        r_rd_pend;
  logic [8:0]  r_pix;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_clr_addr;
  logic [14:0] w_clr_addr_nxt;
  logic [8:0]  r_clr_color;
  logic [8:0]  w_clr_color_nxt;

  logic        w_wr_ready;
  logic        w_busy;
  logic        w_done;
  logic        w_ram_en;
  logic        w_ram_we;
  logic [14:0] w_ram_addr;
  logic [8:0]  w_ram_wdata;

  assign w_vact   = (vc >= c_VBP) && (vc < c_VFP);
  assign w_hact   = (hc >= c_HBP) && (hc < c_HFP);
  assign w_active = w_vact && w_hact;
  // Slots sit two clocks ahead of each 4-pixel cell so the synchronous read lands in time.
  assign w_hphase = hc[1:0] - c_SLOT_FIRST[1:0];
  assign w_slot   = w_vact && (hc >= c_SLOT_FIRST) && (hc <= c_SLOT_LAST) && (w_hphase == 2'b00);

  assign w_scan_addr = r_row_base + {7'd0, r_col};

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      r_col      <= '0;
      r_vsub     <= '0;
      r_row_base <= '0;
    end else begin
      if (hc < c_SLOT_FIRST) begin
        r_col <= '0;
      end else if (w_slot) begin
        r_col <= r_col + 8'd1;
      end
      // Row base steps by one framebuffer row every fourth active line.
      if (vc < c_VBP) begin
        r_vsub     <= '0;
        r_row_base <= '0;
      end else if (w_vact && (hc == c_HFP)) begin
        r_vsub <= r_vsub + 2'd1;
        if (r_vsub == 2'd3) begin
          r_row_base <= r_row_base + c_FB_W;
        end
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      r_rd_pend <= 1'b0;
      r_pix     <= '0;
    end else begin
      r_rd_pend <= w_slot;
      if (r_rd_pend) begin
        r_pix <= ram_rdata;
      end
    end
  end

  assign color = w_active ? r_pix : 9'd0;

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_clr_color <= w_clr_color_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clr_addr_nxt  = r_clr_addr;
    w_clr_color_nxt = r_clr_color;
    w_wr_ready      = 1'b0;
    w_busy          = 1'b0;
    w_done          = 1'b0;
    w_ram_en        = 1'b0;
    w_ram_we        = 1'b0;
    w_ram_addr      = '0;
    w_ram_wdata     = '0;
    if (clr_n) begin
      if (w_slot) begin
        w_ram_en   = 1'b1;
        w_ram_addr = w_scan_addr;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          w_wr_ready = !w_slot;
          // Out-of-range writes still handshake but never reach the RAM.
          if (paint.wr_valid && !w_slot && (paint.wr_addr < c_CELLS)) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = paint.wr_addr;
            w_ram_wdata = paint.wr_data;
          end
          if (r_state == ST_DONE) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (paint.clr_req) begin
            w_state_nxt     = ST_CLEAR;
            w_clr_addr_nxt  = '0;
            w_clr_color_nxt = paint.clr_color;
          end
        end
        ST_CLEAR: begin
          w_busy = 1'b1;
          if (!w_slot) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_addr;
            w_ram_wdata = r_clr_color;
            if (r_clr_addr == c_CELL_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_clr_addr_nxt = r_clr_addr + 15'd1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign paint.wr_ready = w_wr_ready;
  assign paint.clr_busy = w_busy;
  assign paint.clr_done = w_done;
  assign ram_en         = w_ram_en;
  assign ram_we         = w_ram_we;
  assign ram_addr       = w_ram_addr;
  assign ram_wdata      = w_ram_wdata;

endmodule
`default_nettype wire
